// File: rtl/sddr_init_seq.sv
// ============================================================================
// Module   : sddr_init_seq
// Brief    : DDR power-up sequencer writing reset-state register 0x0000.
//            Optional ack timeout enabled by SDDR_INIT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sddr_init_seq #(
    parameter int T_RESET_CYCLES = 10000,
    parameter int T_CKE_CYCLES   = 25000,
    parameter int T_XPR_CYCLES   = 64,
    parameter int ACK_TIMEOUT    = 1024
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  step_o,
    output logic        ctrl_cmd_valid_o,
    output logic [15:0] ctrl_cmd_address_o,
    output logic [31:0] ctrl_cmd_data_o,
    output logic        ctrl_cmd_write_o,
    input  logic        ctrl_cmd_ack_i
);

    localparam int c_MAX_RC  = (T_RESET_CYCLES > T_CKE_CYCLES) ? T_RESET_CYCLES : T_CKE_CYCLES;
    localparam int c_MAX_RCX = (c_MAX_RC > T_XPR_CYCLES) ? c_MAX_RC : T_XPR_CYCLES;
    localparam int c_MAX_ALL = (c_MAX_RCX > ACK_TIMEOUT) ? c_MAX_RCX : ACK_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_MAX_ALL + 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_ERROR = 3'd4;

    // Reset-state word: [0] ddr_reset_n [1] phy_reset_n [2] ctrl_reset [5] cke
    localparam logic [31:0] c_WORD0 = 32'h0000_0000;
    localparam logic [31:0] c_WORD1 = 32'h0000_0003;
    localparam logic [31:0] c_WORD2 = 32'h0000_0023;
    localparam logic [31:0] c_WORD3 = 32'h0000_0027;

    logic [2:0]         r_state;
    logic [1:0]         r_step;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_delay_m1;
    logic [31:0]        w_word;
    logic               w_handshake;

    assign w_handshake = r_valid & ctrl_cmd_ack_i;

    // Counter is loaded with delay-1 so the next valid lands N cycles after the handshake.
    always_comb begin
        w_delay_m1 = '0;
        case (r_step)
            2'd0:    w_delay_m1 = c_CNT_W'(T_RESET_CYCLES - 1);
            2'd1:    w_delay_m1 = c_CNT_W'(T_CKE_CYCLES - 1);
            2'd2:    w_delay_m1 = c_CNT_W'(T_XPR_CYCLES - 1);
            default: w_delay_m1 = '0;
        endcase
    end

    always_comb begin
        w_word = c_WORD0;
        case (r_step)
            2'd0:    w_word = c_WORD0;
            2'd1:    w_word = c_WORD1;
            2'd2:    w_word = c_WORD2;
            default: w_word = c_WORD3;
        endcase
    end

`ifdef SDDR_INIT_TIMEOUT_EN
    logic               r_error;
    logic [c_CNT_W-1:0] r_to_cnt;

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_n_i) begin
            r_error  <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE, c_ST_ERROR: begin
                    if (start_i) begin
                        r_error  <= 1'b0;
                        r_to_cnt <= '0;
                    end
                end
                c_ST_ISSUE: begin
                    if (!w_handshake) begin
                        if (r_to_cnt == c_CNT_W'(ACK_TIMEOUT - 1)) begin
                            r_error <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_ST_WAIT: begin
                    r_to_cnt <= '0;
                end
                default: begin
                    r_to_cnt <= '0;
                end
            endcase
        end
    end

    wire w_timeout = (r_state == c_ST_ISSUE) && !w_handshake &&
                     (r_to_cnt == c_CNT_W'(ACK_TIMEOUT - 1));
    assign error_o = r_error;
`else
    wire w_timeout = 1'b0;
    assign error_o = 1'b0;
`endif

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_n_i) begin
            r_state <= c_ST_IDLE;
            r_step  <= 2'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE, c_ST_ERROR: begin
                    if (start_i) begin
                        r_state <= c_ST_ISSUE;
                        r_step  <= 2'd0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                c_ST_ISSUE: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        if (r_step == 2'd3) begin
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_WAIT;
                            r_count <= w_delay_m1;
                        end
                    end else if (w_timeout) begin
                        r_state <= c_ST_ERROR;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                c_ST_WAIT: begin
                    if (r_count <= c_CNT_W'(1)) begin
                        r_state <= c_ST_ISSUE;
                        r_step  <= r_step + 2'd1;
                        r_valid <= 1'b1;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign step_o             = r_step;
    assign ctrl_cmd_valid_o   = r_valid;
    assign ctrl_cmd_write_o   = r_valid;
    assign ctrl_cmd_address_o = 16'h0000;
    assign ctrl_cmd_data_o    = w_word;

endmodule

`default_nettype wire

// File: tb/tb_sddr_init_seq.sv
// ============================================================================
// Module   : tb_sddr_init_seq
// Brief    : Directed self-checking bench for sddr_init_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sddr_init_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ack;
    logic        busy, done, error, valid, write;
    logic [1:0]  step;
    logic [15:0] addr;
    logic [31:0] data;

    int n_total = 0;
    int n_bad   = 0;
    int vs[4];
    int hs[4];
    logic [31:0] words[4];

    sddr_init_seq #(
        .T_RESET_CYCLES(4),
        .T_CKE_CYCLES  (6),
        .T_XPR_CYCLES  (3),
        .ACK_TIMEOUT   (8)
    ) dut (
        .cpu_clock_i       (clk),
        .cpu_reset_n_i     (rst_n),
        .start_i           (start),
        .busy_o            (busy),
        .done_o            (done),
        .error_o           (error),
        .step_o            (step),
        .ctrl_cmd_valid_o  (valid),
        .ctrl_cmd_address_o(addr),
        .ctrl_cmd_data_o   (data),
        .ctrl_cmd_write_o  (write),
        .ctrl_cmd_ack_i    (ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs cycles 1..ncyc after a start pulse in cycle 0; vs/hs hold valid-rise and handshake cycles.
    task automatic run_seq(input int glitch, input int stall_lo, input int stall_hi, input int ncyc);
        for (int k = 1; k <= ncyc; k++) begin
            int es;
            logic ev;
            tick();
            start = (k == glitch);
            ack   = !(k >= stall_lo && k <= stall_hi);
            es = 0;
            for (int i = 1; i < 4; i++) if (k >= vs[i]) es = i;
            ev = 1'b0;
            for (int i = 0; i < 4; i++) if (k >= vs[i] && k <= hs[i]) ev = 1'b1;
            check($sformatf("valid@%0d", k), {31'd0, valid}, {31'd0, ev});
            check($sformatf("write@%0d", k), {31'd0, write}, {31'd0, ev});
            check($sformatf("step@%0d", k), {30'd0, step}, es);
            check($sformatf("data@%0d", k), data, words[es]);
            check($sformatf("busy@%0d", k), {31'd0, busy}, (k <= hs[3]) ? 1 : 0);
            check($sformatf("done@%0d", k), {31'd0, done}, (k > hs[3]) ? 1 : 0);
            check($sformatf("error@%0d", k), {31'd0, error}, 0);
            if (ev) check($sformatf("addr@%0d", k), {16'd0, addr}, 0);
        end
    endtask

    initial begin
        words = '{32'h0, 32'h3, 32'h23, 32'h27};
        rst_n = 1'b0;
        start = 1'b0;
        ack   = 1'b1;
        repeat (3) tick();
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_done",  {31'd0, done}, 0);
        check("rst_step",  {30'd0, step}, 0);
        check("rst_data",  data, 0);
        rst_n = 1'b1;
        tick();
        check("idle_valid", {31'd0, valid}, 0);

        // Nominal run from IDLE
        start = 1'b1;
        vs = '{1, 5, 11, 14};
        hs = '{1, 5, 11, 14};
        run_seq(-1, -1, -1, 17);

        // Restart from DONE with ack stalled five cycles on step 1
        start = 1'b1;
        vs = '{1, 5, 16, 19};
        hs = '{1, 10, 16, 19};
        run_seq(-1, 5, 9, 21);

        // Restart from DONE with stray start pulses in WAIT
        start = 1'b1;
        vs = '{1, 5, 11, 14};
        hs = '{1, 5, 11, 14};
        run_seq(3, -1, -1, 16);

        // Reset mid-WAIT after step 1, coincident with a start pulse
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            start = 1'b0;
        end
        check("wait_pre_rst_step", {30'd0, step}, 1);
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        check("mid_rst_valid", {31'd0, valid}, 0);
        check("mid_rst_busy",  {31'd0, busy}, 0);
        check("mid_rst_done",  {31'd0, done}, 0);
        check("mid_rst_step",  {30'd0, step}, 0);
        check("mid_rst_data",  data, 0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("post_rst_idle", {31'd0, valid}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_valid", {31'd0, valid}, 1);
        check("restart_step",  {30'd0, step}, 0);
        check("restart_data",  data, 0);
        check("restart_busy",  {31'd0, busy}, 1);

        // Ack withheld forever from step 2 onward
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ack   = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            start = 1'b0;
            ack   = (k < 11);
            if (k >= 11 && k <= 18) check($sformatf("stall_valid@%0d", k), {31'd0, valid}, 1);
        end
`ifdef SDDR_INIT_TIMEOUT_EN
        check("to_error", {31'd0, error}, 1);
        check("to_valid", {31'd0, valid}, 0);
        check("to_busy",  {31'd0, busy}, 0);
        check("to_step",  {30'd0, step}, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_restart_valid", {31'd0, valid}, 1);
        check("to_restart_step",  {30'd0, step}, 0);
        check("to_restart_error", {31'd0, error}, 0);
`else
        repeat (10) tick();
        check("noto_valid", {31'd0, valid}, 1);
        check("noto_error", {31'd0, error}, 0);
        check("noto_step",  {30'd0, step}, 2);
        check("noto_data",  data, 32'h23);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
